// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run/stall/pipeline-reset controller
//
// Owns the CPU run state (idle, wait-calib, free run, N-instruction step),
// merges the external stall sources into one global stall with per-stage
// delayed copies, and generates a pipeline-reset pulse with a delayed chain.
//
// Optional feature macro: CPU_RUN_CTRL_BKPT_EN (adds the breakpoint ports).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_stall_src             external stall requests (OR-merged)
//   i_init_calib_complete   memory calibration done
//   i_cpu_start             start free run (pulse)
//   i_quit_cmd              stop CPU (pulse)
//   i_step_cmd, i_step_num  start a step run of i_step_num instructions
//   o_stall                 combinational global stall
//   o_stall_stg             o_stall delayed 1..PIPE_DEPTH cycles
//   o_stall_1shot           first cycle of a stall
//   o_stall_fin             first unstalled cycle after a stall
//   o_stall_fin2            one cycle after o_stall_fin
//   o_rst_pipe              registered pipeline-reset pulse
//   o_rst_pipe_stg          o_rst_pipe delayed 1..PIPE_DEPTH cycles
//   o_cpu_running           state is RUN or STEP
//   o_step_done             one-cycle pulse when a step run completes
//   i_bkpt_en, i_bkpt_addr, i_pc_id, o_bkpt_hit   (CPU_RUN_CTRL_BKPT_EN only)
module cpu_run_ctrl #(
    parameter int PIPE_DEPTH = 4,
    parameter int NSTALL     = 2,
    parameter int STEP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSTALL-1:0]     i_stall_src,
    input  logic                  i_init_calib_complete,
    input  logic                  i_cpu_start,
    input  logic                  i_quit_cmd,
    input  logic                  i_step_cmd,
    input  logic [STEP_W-1:0]     i_step_num,
`ifdef CPU_RUN_CTRL_BKPT_EN
    input  logic                  i_bkpt_en,
    input  logic [31:0]           i_bkpt_addr,
    input  logic [31:0]           i_pc_id,
    output logic                  o_bkpt_hit,
`endif
    output logic                  o_stall,
    output logic [PIPE_DEPTH-1:0] o_stall_stg,
    output logic                  o_stall_1shot,
    output logic                  o_stall_fin,
    output logic                  o_stall_fin2,
    output logic                  o_rst_pipe,
    output logic [PIPE_DEPTH-1:0] o_rst_pipe_stg,
    output logic                  o_cpu_running,
    output logic                  o_step_done
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_CALIB = 2'd1,
        S_RUN        = 2'd2,
        S_STEP       = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [STEP_W-1:0]     r_step_cnt;
    logic [PIPE_DEPTH-1:0] r_stall_stg;
    logic [PIPE_DEPTH-1:0] r_rst_pipe_stg;
    logic                  r_rst_pipe;
    logic                  r_step_done;

    logic w_running;
    logic w_stall;
    logic w_abort;
    logic w_break;
    logic w_rst_pipe_set;
    logic w_step_done_set;
    logic w_step_load;
    logic w_step_dec;

    assign w_running = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_stall   = ~w_running | (|i_stall_src);
    // Loss of calibration is treated like a quit while the CPU is running.
    assign w_abort   = i_quit_cmd | ~i_init_calib_complete;

`ifdef CPU_RUN_CTRL_BKPT_EN
    // A break only takes effect on an instruction that actually advances.
    assign w_break = w_running & ~w_stall & i_bkpt_en & (i_pc_id == i_bkpt_addr);
`else
    assign w_break = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_rst_pipe_set  = 1'b0;
        w_step_done_set = 1'b0;
        w_step_load     = 1'b0;
        w_step_dec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_quit_cmd) begin
                    if (i_cpu_start) begin
                        if (i_init_calib_complete) begin
                            w_next_state   = S_RUN;
                            w_rst_pipe_set = 1'b1;
                        end else begin
                            w_next_state   = S_WAIT_CALIB;
                        end
                    end else if (i_step_cmd && i_init_calib_complete &&
                                 (i_step_num != '0)) begin
                        w_next_state   = S_STEP;
                        w_step_load    = 1'b1;
                        w_rst_pipe_set = 1'b1;
                    end
                end
            end
            S_WAIT_CALIB: begin
                if (i_quit_cmd) begin
                    w_next_state = S_IDLE;
                end else if (i_init_calib_complete) begin
                    w_next_state   = S_RUN;
                    w_rst_pipe_set = 1'b1;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next_state   = S_IDLE;
                    w_rst_pipe_set = 1'b1;
                end else if (w_break) begin
                    w_next_state = S_IDLE;
                end
            end
            S_STEP: begin
                if (w_abort) begin
                    w_next_state   = S_IDLE;
                    w_rst_pipe_set = 1'b1;
                end else if (w_break) begin
                    w_next_state = S_IDLE;
                end else if (!w_stall) begin
                    w_step_dec = 1'b1;
                    // Normal completion keeps pipeline state: no rst_pipe here.
                    if (r_step_cnt == STEP_W'(1)) begin
                        w_next_state    = S_IDLE;
                        w_step_done_set = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt     <= '0;
            r_stall_stg    <= '1;
            r_rst_pipe     <= 1'b0;
            r_rst_pipe_stg <= '0;
            r_step_done    <= 1'b0;
        end else begin
            if (w_step_load) begin
                r_step_cnt <= i_step_num;
            end else if (w_step_dec) begin
                r_step_cnt <= r_step_cnt - STEP_W'(1);
            end
            r_stall_stg    <= {r_stall_stg[PIPE_DEPTH-2:0], w_stall};
            r_rst_pipe     <= w_rst_pipe_set;
            r_rst_pipe_stg <= {r_rst_pipe_stg[PIPE_DEPTH-2:0], r_rst_pipe};
            r_step_done    <= w_step_done_set;
        end
    end

`ifdef CPU_RUN_CTRL_BKPT_EN
    logic r_bkpt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bkpt_hit <= 1'b0;
        end else begin
            r_bkpt_hit <= w_break & ~w_abort;
        end
    end

    assign o_bkpt_hit = r_bkpt_hit;
`endif

    assign o_stall        = w_stall;
    assign o_stall_stg    = r_stall_stg;
    assign o_stall_1shot  = w_stall & ~r_stall_stg[0];
    assign o_stall_fin    = ~w_stall & r_stall_stg[0];
    assign o_stall_fin2   = ~r_stall_stg[0] & r_stall_stg[1];
    assign o_rst_pipe     = r_rst_pipe;
    assign o_rst_pipe_stg = r_rst_pipe_stg;
    assign o_cpu_running  = w_running;
    assign o_step_done    = r_step_done;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int PIPE_DEPTH = 4;
    localparam int NSTALL     = 2;
    localparam int STEP_W     = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NSTALL-1:0]     i_stall_src;
    logic                  i_init_calib_complete;
    logic                  i_cpu_start;
    logic                  i_quit_cmd;
    logic                  i_step_cmd;
    logic [STEP_W-1:0]     i_step_num;
    logic                  o_stall;
    logic [PIPE_DEPTH-1:0] o_stall_stg;
    logic                  o_stall_1shot;
    logic                  o_stall_fin;
    logic                  o_stall_fin2;
    logic                  o_rst_pipe;
    logic [PIPE_DEPTH-1:0] o_rst_pipe_stg;
    logic                  o_cpu_running;
    logic                  o_step_done;
`ifdef CPU_RUN_CTRL_BKPT_EN
    logic                  i_bkpt_en;
    logic [31:0]           i_bkpt_addr;
    logic [31:0]           i_pc_id;
    logic                  o_bkpt_hit;
`endif

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .PIPE_DEPTH(PIPE_DEPTH),
        .NSTALL    (NSTALL),
        .STEP_W    (STEP_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_stall_src          (i_stall_src),
        .i_init_calib_complete(i_init_calib_complete),
        .i_cpu_start          (i_cpu_start),
        .i_quit_cmd           (i_quit_cmd),
        .i_step_cmd           (i_step_cmd),
        .i_step_num           (i_step_num),
`ifdef CPU_RUN_CTRL_BKPT_EN
        .i_bkpt_en            (i_bkpt_en),
        .i_bkpt_addr          (i_bkpt_addr),
        .i_pc_id              (i_pc_id),
        .o_bkpt_hit           (o_bkpt_hit),
`endif
        .o_stall              (o_stall),
        .o_stall_stg          (o_stall_stg),
        .o_stall_1shot        (o_stall_1shot),
        .o_stall_fin          (o_stall_fin),
        .o_stall_fin2         (o_stall_fin2),
        .o_rst_pipe           (o_rst_pipe),
        .o_rst_pipe_stg       (o_rst_pipe_stg),
        .o_cpu_running        (o_cpu_running),
        .o_step_done          (o_step_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: run flags plus remaining-instruction count, and
    // output histories kept as queues (index 0 = one cycle ago).
    bit m_run, m_wait, m_step;
    int m_left;
    bit m_rst_pipe, m_done, m_hit;
    bit stall_hist[$];
    bit rst_hist[$];

    int unstalled_cnt, done_cnt, rst_cnt, oneshot_cnt, fin_cnt, fin2_cnt;

    function automatic void model_reset();
        m_run = 0; m_wait = 0; m_step = 0; m_left = 0;
        m_rst_pipe = 0; m_done = 0; m_hit = 0;
        stall_hist = {};
        rst_hist   = {};
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            stall_hist.push_back(1'b1);
            rst_hist.push_back(1'b0);
        end
    endfunction

    function automatic bit exp_stall();
        return !m_run || (i_stall_src != '0);
    endfunction

    task automatic check_all();
        bit s;
        logic [PIPE_DEPTH-1:0] es;
        logic [PIPE_DEPTH-1:0] er;
        s = exp_stall();
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            es[i] = stall_hist[i];
            er[i] = rst_hist[i];
        end
        check_val("stall", o_stall, s);
        check_val("running", o_cpu_running, m_run);
        check_val("stall_stg", o_stall_stg, es);
        check_val("stall_1shot", o_stall_1shot, s & !stall_hist[0]);
        check_val("stall_fin", o_stall_fin, !s & stall_hist[0]);
        check_val("stall_fin2", o_stall_fin2, !stall_hist[0] & stall_hist[1]);
        check_val("rst_pipe", o_rst_pipe, m_rst_pipe);
        check_val("rst_pipe_stg", o_rst_pipe_stg, er);
        check_val("step_done", o_step_done, m_done);
`ifdef CPU_RUN_CTRL_BKPT_EN
        check_val("bkpt_hit", o_bkpt_hit, m_hit);
`endif
    endtask

    // Advance the model across one active edge using the inputs now applied.
    task automatic model_step();
        bit s, brk, nr, nd, nh;
        s = exp_stall();
        brk = 0; nr = 0; nd = 0; nh = 0;
`ifdef CPU_RUN_CTRL_BKPT_EN
        brk = m_run && !s && i_bkpt_en && (i_pc_id == i_bkpt_addr);
`endif
        stall_hist.push_front(s);
        void'(stall_hist.pop_back());
        rst_hist.push_front(m_rst_pipe);
        void'(rst_hist.pop_back());
        if (m_run) begin
            if (i_quit_cmd || !i_init_calib_complete) begin
                m_run = 0; m_step = 0; nr = 1;
            end else if (brk) begin
                m_run = 0; m_step = 0; nh = 1;
            end else if (m_step && !s) begin
                m_left--;
                if (m_left == 0) begin
                    m_run = 0; m_step = 0; nd = 1;
                end
            end
        end else if (m_wait) begin
            if (i_quit_cmd) begin
                m_wait = 0;
            end else if (i_init_calib_complete) begin
                m_wait = 0; m_run = 1; nr = 1;
            end
        end else if (!i_quit_cmd) begin
            if (i_cpu_start) begin
                if (i_init_calib_complete) begin
                    m_run = 1; nr = 1;
                end else begin
                    m_wait = 1;
                end
            end else if (i_step_cmd && i_init_calib_complete && i_step_num != 0) begin
                m_run = 1; m_step = 1; m_left = int'(i_step_num); nr = 1;
            end
        end
        m_rst_pipe = nr; m_done = nd; m_hit = nh;
    endtask

    task automatic clear_counts();
        unstalled_cnt = 0; done_cnt = 0; rst_cnt = 0;
        oneshot_cnt = 0; fin_cnt = 0; fin2_cnt = 0;
    endtask

    // One clock: apply inputs just after an edge, check mid-cycle, step model.
    task automatic cycle(input bit q, input bit c, input bit st, input bit sp,
                         input int num, input int src);
        i_quit_cmd            = q;
        i_init_calib_complete = c;
        i_cpu_start           = st;
        i_step_cmd            = sp;
        i_step_num            = STEP_W'(num);
        i_stall_src           = NSTALL'(src);
        #1;
        check_all();
        if (o_stall == 1'b0) unstalled_cnt++;
        if (o_step_done) done_cnt++;
        if (o_rst_pipe) rst_cnt++;
        if (o_stall_1shot) oneshot_cnt++;
        if (o_stall_fin) fin_cnt++;
        if (o_stall_fin2) fin2_cnt++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit c);
        for (int i = 0; i < n; i++) cycle(0, c, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input bit chk_async);
        rst_n = 1'b0;
        #1;
        model_reset();
        if (chk_async) check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        i_quit_cmd = 0; i_init_calib_complete = 1; i_cpu_start = 0;
        i_step_cmd = 0; i_step_num = '0; i_stall_src = '0;
`ifdef CPU_RUN_CTRL_BKPT_EN
        i_bkpt_en = 0; i_bkpt_addr = 32'h100; i_pc_id = 32'h0;
`endif
        clear_counts();
        rst_n = 1'b1;
        #2;
        do_reset(1'b1);
        check_val("rst_stall", o_stall, 1);
        check_val("rst_stall_stg", o_stall_stg, {PIPE_DEPTH{1'b1}});

        // Free run start with the delayed reset chain.
        cycle(0, 1, 1, 0, 0, 0);
        check_val("start_running", o_cpu_running, 1);
        check_val("start_rst_pipe", o_rst_pipe, 1);
        idle_cycles(6, 1);

        // Wait for calibration, then enter RUN when it arrives.
        cycle(1, 1, 0, 0, 0, 0);
        idle_cycles(2, 1);
        cycle(0, 0, 1, 0, 0, 0);
        idle_cycles(10, 0);
        check_val("wait_not_running", o_cpu_running, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check_val("calib_run", o_cpu_running, 1);
        cycle(1, 1, 0, 0, 0, 0);
        idle_cycles(6, 1);

        // Quit while waiting for calibration: no pipeline reset.
        clear_counts();
        cycle(0, 0, 1, 0, 0, 0);
        idle_cycles(3, 0);
        cycle(1, 0, 0, 0, 0, 0);
        idle_cycles(3, 1);
        check_val("waitq_rst_cnt", rst_cnt, 0);
        check_val("waitq_running", o_cpu_running, 0);

        // Step of 3 with a stall on the second step cycle.
        clear_counts();
        cycle(0, 1, 0, 1, 3, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1);
        idle_cycles(6, 1);
        check_val("step_unstalled", unstalled_cnt, 3);
        check_val("step_done_cnt", done_cnt, 1);
        check_val("step_rst_cnt", rst_cnt, 1);

        // Stall edge detectors during RUN.
        cycle(0, 1, 1, 0, 0, 0);
        idle_cycles(3, 1);
        clear_counts();
        cycle(0, 1, 0, 0, 0, 2);
        cycle(0, 1, 0, 0, 0, 2);
        idle_cycles(4, 1);
        check_val("oneshot_cnt", oneshot_cnt, 1);
        check_val("fin_cnt", fin_cnt, 1);
        check_val("fin2_cnt", fin2_cnt, 1);

        // Quit and start together while running; then a zero-length step.
        clear_counts();
        cycle(1, 1, 1, 0, 0, 0);
        check_val("qs_running", o_cpu_running, 0);
        check_val("qs_rst_pipe", o_rst_pipe, 1);
        cycle(0, 1, 0, 1, 0, 0);
        check_val("step0_idle", o_cpu_running, 0);
        idle_cycles(5, 1);

`ifdef CPU_RUN_CTRL_BKPT_EN
        // Breakpoint hit while unstalled.
        cycle(0, 1, 1, 0, 0, 0);
        i_bkpt_en = 1; i_bkpt_addr = 32'h100; i_pc_id = 32'h100;
        cycle(0, 1, 0, 0, 0, 0);
        i_bkpt_en = 0;
        check_val("bkpt_hit_dir", o_bkpt_hit, 1);
        check_val("bkpt_running", o_cpu_running, 0);
        idle_cycles(3, 1);
`endif

        // Mid-step asynchronous reset discards the step.
        cycle(0, 1, 0, 1, 5, 0);
        cycle(0, 1, 0, 0, 0, 0);
        do_reset(1'b1);
        clear_counts();
        idle_cycles(4, 1);
        check_val("rst_step_done_cnt", done_cnt, 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            bit q, c, st, sp;
            int num, src;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'b1);
            end else begin
                q   = ($urandom_range(0, 99) < 4);
                c   = ($urandom_range(0, 99) < 93);
                st  = ($urandom_range(0, 99) < 8);
                sp  = ($urandom_range(0, 99) < 12);
                num = (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7)));
                src = 0;
                for (int b = 0; b < NSTALL; b++)
                    if ($urandom_range(0, 99) < 20) src = src | (1 << b);
`ifdef CPU_RUN_CTRL_BKPT_EN
                i_bkpt_en   = ($urandom_range(0, 99) < 30);
                i_bkpt_addr = 32'h100;
                i_pc_id     = ($urandom_range(0, 99) < 10) ? 32'h100 : $urandom();
`endif
                cycle(q, c, st, sp, num, src);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
